ramp_checker: RTL and testbench

- Stream sink for the ramp source. Consumes a valid/ready stream and checks that data follows the ramp 0,1,…,MAX_VALUE-1,0,… with wrap.
- Reports accepted-sample count, mismatch count, last bad value and completion.
- Sits at the far end of loopback/datapath test chains as the self-checking endpoint.

---
 rtl/ramp_pkg.sv | 30 +++
 rtl/sat_counter.sv | 34 +++
 rtl/ramp_checker.sv | 177 +++++++++++++++++
 tb/tb_ramp_checker.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ramp_pkg.sv
// ============================================================================
// Package : ramp_pkg
// Shared ramp definitions: checker state type, default geometry, wrap helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ramp_pkg;

    localparam int RAMP_DATA_WIDTH = 16;
    localparam int RAMP_MAX_VALUE  = 1000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        CHECK   = 2'd2,
        DONE    = 2'd3
    } ramp_chk_state_t;

    // Successor on a ramp of period max: max-1 wraps to 0.
    function automatic logic [31:0] ramp_next(input logic [31:0] x, input logic [31:0] max);
        logic [31:0] r;
        if (x == max - 32'd1) r = 32'd0;
        else                  r = x + 32'd1;
        return r;
    endfunction

endpackage : ramp_pkg

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule : sat_counter

`default_nettype wire

// File: rtl/ramp_checker.sv
// ============================================================================
// Module  : ramp_checker
// Valid/ready sink that checks a wrapping 0..MAX_VALUE-1 ramp and reports
// sample/error counts. Optional ready throttle under RAMP_CHECKER_BP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ramp_checker
    import ramp_pkg::*;
#(
    parameter int DATA_WIDTH  = RAMP_DATA_WIDTH,
    parameter int MAX_VALUE   = RAMP_MAX_VALUE,
    parameter int NUM_SAMPLES = 4096,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid,
    output logic                  ready,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [7:0]            bp_pattern,
    output logic [CNT_WIDTH-1:0]  sample_count,
    output logic [CNT_WIDTH-1:0]  error_count,
    output logic [DATA_WIDTH-1:0] last_err_data,
    output logic                  locked,
    output logic                  done
);

    ramp_chk_state_t       r_state;
    ramp_chk_state_t       w_state_nxt;
    logic [DATA_WIDTH-1:0] r_expected;
    logic [DATA_WIDTH-1:0] r_last_err;
    logic                  r_locked;
    logic                  r_done;

    logic                  w_state_ready;
    logic                  w_beat;
    logic                  w_data_oor;
    logic                  w_data_match;
    logic                  w_count_hit;
    logic                  w_err_inc;
    logic [DATA_WIDTH-1:0] w_next_of_data;
    logic [DATA_WIDTH-1:0] w_next_of_exp;
    logic [CNT_WIDTH-1:0]  w_sample_count;
    logic [CNT_WIDTH-1:0]  w_error_count;

    assign w_state_ready  = (r_state == ACQUIRE) || (r_state == CHECK);
    assign w_beat         = valid && ready;
    assign w_data_oor     = (32'(data) >= 32'(MAX_VALUE));
    assign w_data_match   = (data == r_expected);
    assign w_next_of_data = DATA_WIDTH'(ramp_next(32'(data), 32'(MAX_VALUE)));
    assign w_next_of_exp  = DATA_WIDTH'(ramp_next(32'(r_expected), 32'(MAX_VALUE)));
    assign w_count_hit    = (w_sample_count == CNT_WIDTH'(NUM_SAMPLES - 1));
    assign w_err_inc      = w_beat && (((r_state == ACQUIRE) && w_data_oor) ||
                                       ((r_state == CHECK) && !w_data_match));

`ifdef RAMP_CHECKER_BP_EN
    logic [7:0] r_rot;

    // Pattern is latched on the IDLE->ACQUIRE transition; zero means no throttle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rot <= '0;
        end else if ((r_state == IDLE) && (w_state_nxt == ACQUIRE)) begin
            r_rot <= (bp_pattern == 8'h00) ? 8'hFF : bp_pattern;
        end else if (w_state_ready) begin
            r_rot <= {r_rot[6:0], r_rot[7]};
        end
    end

    assign ready = w_state_ready && r_rot[7];
`else
    logic w_unused_bp;
    assign w_unused_bp = ^bp_pattern;
    assign ready       = w_state_ready;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (enable) w_state_nxt = ACQUIRE;
            end
            ACQUIRE: begin
                if (!enable)     w_state_nxt = IDLE;
                else if (w_beat) w_state_nxt = w_count_hit ? DONE : CHECK;
            end
            CHECK: begin
                if (!enable)                    w_state_nxt = IDLE;
                else if (w_beat && w_count_hit) w_state_nxt = DONE;
            end
            DONE: begin
                if (!enable) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (clear) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_expected <= '0;
            r_last_err <= '0;
            r_locked   <= 1'b0;
            r_done     <= 1'b0;
        end else if (clear) begin
            r_expected <= '0;
            r_last_err <= '0;
            r_locked   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ACQUIRE: begin
                    if (w_beat) begin
                        r_locked <= 1'b1;
                        if (w_data_oor) begin
                            r_last_err <= data;
                            r_expected <= '0;
                        end else begin
                            r_expected <= w_next_of_data;
                        end
                    end
                end
                CHECK: begin
                    // A mismatch resyncs on the received value so a drop costs one error.
                    if (w_beat) begin
                        if (w_data_match) begin
                            r_expected <= w_next_of_exp;
                        end else begin
                            r_last_err <= data;
                            r_expected <= w_next_of_data;
                        end
                    end
                end
                default: ;
            endcase
            if ((r_state != DONE) && (w_state_nxt == DONE)) r_done <= 1'b1;
            if (!enable) r_locked <= 1'b0;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_sample_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_beat),
        .i_clr   (clear),
        .o_count (w_sample_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_error_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_err_inc),
        .i_clr   (clear),
        .o_count (w_error_count)
    );

    assign sample_count  = w_sample_count;
    assign error_count   = w_error_count;
    assign last_err_data = r_last_err;
    assign locked        = r_locked;
    assign done          = r_done;

endmodule : ramp_checker

`default_nettype wire

// File: tb/tb_ramp_checker.sv
// ============================================================================
// Module  : tb_ramp_checker
// Directed bench for ramp_checker (MAX_VALUE=8, NUM_SAMPLES=20).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ramp_checker;

    localparam int DW = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic          enable;
    logic          clear;
    logic [7:0]    bp_pattern;
    logic [CW-1:0] sample_count;
    logic [CW-1:0] error_count;
    logic [DW-1:0] last_err_data;
    logic          locked;
    logic          done;

    int errors = 0;
    int checks = 0;

    ramp_checker #(
        .DATA_WIDTH  (DW),
        .MAX_VALUE   (8),
        .NUM_SAMPLES (20),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid         (valid),
        .ready         (ready),
        .data          (data),
        .enable        (enable),
        .clear         (clear),
        .bp_pattern    (bp_pattern),
        .sample_count  (sample_count),
        .error_count   (error_count),
        .last_err_data (last_err_data),
        .locked        (locked),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input int v);
        valid = 1'b1;
        data  = DW'(v);
        tick();
    endtask

    initial begin
        int nd;
        logic acc;
        rst_n = 1'b0; valid = 1'b0; data = '0; enable = 1'b0; clear = 1'b0; bp_pattern = 8'h00;
        tick(); tick();
        check("rst_sample", sample_count, 0);
        check("rst_error", error_count, 0);
        check("rst_lasterr", last_err_data, 0);
        check("rst_locked", locked, 0);
        check("rst_done", done, 0);
        check("rst_ready", ready, 0);
        rst_n = 1'b1;
        tick();
        check("idle_ready", ready, 0);

        // Clean ramp: 20 beats 0..7,0..7,0..3
        enable = 1'b1;
        tick();
        check("acq_ready", ready, 1);
        for (int i = 0; i < 20; i++) beat(i % 8);
        check("clean_sample", sample_count, 20);
        check("clean_error", error_count, 0);
        check("clean_done", done, 1);
        check("clean_ready", ready, 0);
        check("clean_locked", locked, 1);
        tick();
        check("done_hold_sample", sample_count, 20);
        valid = 1'b0; enable = 1'b0;
        tick();
        check("done_abort_done", done, 1);
        check("done_abort_locked", locked, 0);
        check("done_abort_sample", sample_count, 20);

        // Wrap plus drop: 5,6,7,0,2,3,4
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_sample", sample_count, 0);
        check("clr_done", done, 0);
        enable = 1'b1;
        tick();
        beat(5); beat(6); beat(7); beat(0);
        check("wrap_error", error_count, 0);
        beat(2);
        check("drop_error", error_count, 1);
        check("drop_lasterr", last_err_data, 2);
        beat(3); beat(4);
        check("drop_after_error", error_count, 1);
        check("drop_after_sample", sample_count, 7);

        // Mid-stream acquire: 6,7,0,1
        valid = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr2_error", error_count, 0);
        check("clr2_lasterr", last_err_data, 0);
        tick();
        beat(6);
        check("mid_locked", locked, 1);
        check("mid_sample1", sample_count, 1);
        beat(7); beat(0); beat(1);
        check("mid_error", error_count, 0);
        check("mid_sample", sample_count, 4);

        // Out-of-range acquire beat: error, expected restarts at 0
        valid = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        beat(9);
        check("oor_error", error_count, 1);
        check("oor_lasterr", last_err_data, 9);
        beat(0); beat(1);
        check("oor_follow_error", error_count, 1);

        // Abort with a coincident beat, resume, then clear with a beat
        valid = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        beat(0); beat(1); beat(2); beat(3);
        enable = 1'b0;
        beat(4);
        check("abort_sample", sample_count, 5);
        check("abort_ready", ready, 0);
        check("abort_locked", locked, 0);
        check("abort_error", error_count, 0);
        data = DW'(5);
        tick();
        check("abort_hold_sample", sample_count, 5);
        enable = 1'b1;
        tick();
        check("resume_ready", ready, 1);
        check("resume_nobeat", sample_count, 5);
        beat(5);
        check("resume_sample", sample_count, 6);
        check("resume_locked", locked, 1);
        beat(2);
        check("resume_mis_error", error_count, 1);
        check("resume_mis_lasterr", last_err_data, 2);
        clear = 1'b1;
        beat(3);
        clear = 1'b0;
        check("clrbeat_sample", sample_count, 0);
        check("clrbeat_error", error_count, 0);
        check("clrbeat_lasterr", last_err_data, 0);
        check("clrbeat_locked", locked, 0);
        check("clrbeat_ready", ready, 0);

        // Async reset in CHECK with valid held high
        valid = 1'b0;
        tick();
        beat(0); beat(1); beat(2);
        check("pre_rst_sample", sample_count, 3);
        data  = DW'(3);
        rst_n = 1'b0;
        #1;
        check("arst_sample", sample_count, 0);
        check("arst_locked", locked, 0);
        check("arst_ready", ready, 0);
        #14;
        rst_n = 1'b1;
        tick();
        check("arst_nobeat", sample_count, 0);
        check("arst_reacq_ready", ready, 1);

        // Throttle: 20 cycles of always-valid source
        valid = 1'b0; bp_pattern = 8'b1010_1010; clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        nd = 0;
        valid = 1'b1;
        data = '0;
        for (int k = 0; k < 20; k++) begin
            acc = ready;
            tick();
            if (acc) begin
                nd++;
                data = DW'(nd % 8);
            end
        end
        valid = 1'b0;
`ifdef RAMP_CHECKER_BP_EN
        check("thr_sample", sample_count, 10);
        check("thr_done", done, 0);
`else
        check("thr_sample", sample_count, 20);
        check("thr_done", done, 1);
`endif
        check("thr_error", error_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ramp_checker

`default_nettype wire
